ysyx_22040127_wb_scoreboard: RTL and testbench

Write-side partner of the GPR file: it collects writeback results from the ALU and LSU, queues them, and drives the register file's single write port (`wen`/`waddr`/`wdata`) at one write per cycle. It also keeps a per-register busy scoreboard. Issue allocates the destination register, and the decode stage checks its two source registers for hazards. It sits between the execute/memory stages and the register file.

---
 rtl/ysyx_22040127_pkg.sv | 15 +
 rtl/ysyx_22040127_wb_fifo.sv | 53 +++++
 rtl/ysyx_22040127_wb_scoreboard.sv | 105 ++++++++++
 tb/tb_ysyx_22040127_wb_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_pkg.sv
// rtl/ysyx_22040127_pkg.sv - shared widths, writeback entry type and register constants
// Contents: default GPR index/data widths, the {rd, data} writeback entry
// struct, and the hard-wired zero register index.
package ysyx_22040127_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 64;
  localparam int ZERO_REG      = 0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_22040127_wb_fifo.sv
// rtl/ysyx_22040127_wb_fifo.sv - parameterised synchronous FIFO for writeback entries
// Ports: clk, rst_n (async active-low); push/push_data enqueue;
// pop dequeues the head shown on pop_data; full/empty/count report occupancy.
// Push while full and pop while empty are ignored.
module ysyx_22040127_wb_fifo
  import ysyx_22040127_pkg::*;
#(
  parameter int WIDTH = WB_ADDR_WIDTH + WB_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign count    = wptr - rptr;
  assign pop_data = mem[rptr[PW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ysyx_22040127_wb_scoreboard.sv
// rtl/ysyx_22040127_wb_scoreboard.sv - writeback arbiter, queue and busy scoreboard for the GPR file
// Ports: clk, rst_n (async active-low);
//   alloc_valid/alloc_rd/alloc_ready  - issue marks a destination busy
//   alu_* / lsu_*                     - writeback producers (LSU has priority)
//   rf_wen/rf_waddr/rf_wdata          - register file write port, one write per cycle
//   chk_raddr1/2 -> hazard1/2         - decode source hazard lookup
//   pending                           - writeback queue occupancy
module ysyx_22040127_wb_scoreboard
  import ysyx_22040127_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_valid,
  input  logic [ADDR_WIDTH-1:0]   alloc_rd,
  output logic                    alloc_ready,
  input  logic                    alu_valid,
  input  logic [ADDR_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  output logic                    alu_ready,
  input  logic                    lsu_valid,
  input  logic [ADDR_WIDTH-1:0]   lsu_rd,
  input  logic [DATA_WIDTH-1:0]   lsu_data,
  output logic                    lsu_ready,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  input  logic [ADDR_WIDTH-1:0]   chk_raddr1,
  input  logic [ADDR_WIDTH-1:0]   chk_raddr2,
  output logic                    hazard1,
  output logic                    hazard2,
  output logic [$clog2(DEPTH):0]  pending
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_REG);

  logic             full;
  logic             empty;
  logic             lsu_fire;
  logic             alu_fire;
  logic             push;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             alloc_fire;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Ready comes from the registered full flag only, so a pop never lets a
  // producer slip into the slot it frees in the same cycle.
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign alu_fire  = alu_valid && alu_ready;

  // x0 writebacks complete the handshake but are dropped here.
  assign push      = (lsu_fire && lsu_rd != X0) || (alu_fire && alu_rd != X0);
  assign push_data = lsu_fire ? {lsu_rd, lsu_data} : {alu_rd, alu_data};

  ysyx_22040127_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (!empty),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  // Head pops every non-empty cycle; address/data read as zero when idle.
  assign rf_wen   = !empty;
  assign rf_waddr = empty ? '0 : head[EW-1:DATA_WIDTH];
  assign rf_wdata = empty ? '0 : head[DATA_WIDTH-1:0];

  assign alloc_ready = !busy[alloc_rd];
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_rd != X0);
  assign hazard1     = busy[chk_raddr1];
  assign hazard2     = busy[chk_raddr2];

  always_comb begin
    busy_nxt = busy;
    if (rf_wen)     busy_nxt[rf_waddr] = 1'b0;
    if (alloc_fire) busy_nxt[alloc_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // A register being allocated is never busy, so it cannot also be committing.
  a_no_set_clear_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(alloc_fire && rf_wen && (rf_waddr == alloc_rd)));

endmodule

// File: tb/tb_ysyx_22040127_wb_scoreboard.sv
// tb/tb_ysyx_22040127_wb_scoreboard.sv - self-checking bench for ysyx_22040127_wb_scoreboard
module tb_ysyx_22040127_wb_scoreboard;
  import ysyx_22040127_pkg::*;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          alloc_valid;
  logic [AW-1:0] alloc_rd;
  logic          alloc_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_raddr1;
  logic [AW-1:0] chk_raddr2;
  logic          hazard1;
  logic          hazard2;
  logic [2:0]    pending;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of writes still owed to the register file,
  // and the set of registers with a write outstanding.
  wb_entry_t q[$];
  bit        mbusy[32];
  bit        acc_alu, acc_lsu, acc_alloc;
  int        outst[$];

  ysyx_22040127_wb_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_raddr1(chk_raddr1), .chk_raddr2(chk_raddr2),
    .hazard1(hazard1), .hazard2(hazard2), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    outst.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    acc_alu = 0; acc_lsu = 0; acc_alloc = 0;
  endtask

  // Advance one clock: apply the handshake rules to the current inputs, then
  // let the edge happen and return at the following negedge.
  task automatic tick();
    bit full;
    wb_entry_t e;
    full      = (q.size() == DEPTH);
    acc_lsu   = lsu_valid && !full;
    acc_alu   = alu_valid && !full && !lsu_valid;
    acc_alloc = alloc_valid && !mbusy[alloc_rd];
    if (q.size() > 0) begin
      mbusy[q[0].rd] = 1'b0;
      q.delete(0);
    end
    if (acc_lsu && lsu_rd != 0) begin
      e.rd = lsu_rd; e.data = lsu_data; q.push_back(e);
    end else if (acc_alu && alu_rd != 0) begin
      e.rd = alu_rd; e.data = alu_data; q.push_back(e);
    end
    if (acc_alloc && alloc_rd != 0) mbusy[alloc_rd] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    chk_raddr1 = 0; chk_raddr2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    chk_raddr1 = 5'd3; chk_raddr2 = 5'd17; alloc_rd = 5'd9;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b exp 0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", rf_waddr); end
    checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got %0h exp 0", rf_wdata); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if ({alu_ready, lsu_ready, alloc_ready} !== 3'b111) begin errors++; $display("FAIL reset_ready got %b exp 111", {alu_ready, lsu_ready, alloc_ready}); end
    checks++; if ({hazard1, hazard2} !== 2'b00) begin errors++; $display("FAIL reset_hazard got %b exp 00", {hazard1, hazard2}); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 64'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %0b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd5}) begin errors++; $display("FAIL single_write got wen %0b addr %0d exp 1 5", rf_wen, rf_waddr); end
    checks++; if (rf_wdata !== 64'h1234) begin errors++; $display("FAIL single_wdata got %0h exp 1234", rf_wdata); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL single_pending1 got %0d exp 1", pending); end
    tick();
    #1;
    checks++; if ({rf_wen, pending} !== {1'b0, 3'd0}) begin errors++; $display("FAIL single_drain got wen %0b pend %0d exp 0 0", rf_wen, pending); end
  endtask

  task automatic test_hazard();
    alloc_valid = 1; alloc_rd = 5'd7; chk_raddr1 = 5'd7;
    #1;
    checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL hazard_before_alloc got %0b exp 0", hazard1); end
    tick();
    alloc_valid = 0;
    #1;
    checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL hazard_after_alloc got %0b exp 1", hazard1); end
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 64'hCAFE;
    tick();
    lsu_valid = 0;
    #1;
    checks++; if ({rf_wen, rf_waddr, hazard1} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL hazard_wen_cycle got wen %0b addr %0d hz %0b exp 1 7 1", rf_wen, rf_waddr, hazard1); end
    tick();
    #1;
    checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL hazard_after_commit got %0b exp 0", hazard1); end
  endtask

  task automatic test_arbitration();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 64'hA3;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 64'hB4;
    #1;
    checks++; if ({lsu_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL arb_ready got %b exp 10", {lsu_ready, alu_ready}); end
    tick();
    lsu_valid = 0;
    #1;
    checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 64'hB4}) begin errors++; $display("FAIL arb_lsu_first got %0b %0d %0h exp 1 4 b4", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL arb_alu_ready got %0b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 64'hA3}) begin errors++; $display("FAIL arb_alu_second got %0b %0d %0h exp 1 3 a3", rf_wen, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 64'hFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_wb_ready got %0b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    checks++; if ({rf_wen, pending} !== {1'b0, 3'd0}) begin errors++; $display("FAIL x0_no_write got wen %0b pend %0d exp 0 0", rf_wen, pending); end
    alloc_valid = 1; alloc_rd = 5'd0; chk_raddr1 = 5'd0; chk_raddr2 = 5'd0;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL x0_alloc_ready got %0b exp 1", alloc_ready); end
    tick();
    #1;
    checks++; if ({alloc_ready, hazard1, hazard2} !== 3'b100) begin errors++; $display("FAIL x0_not_busy got %b exp 100", {alloc_ready, hazard1, hazard2}); end
    alloc_valid = 0;
  endtask

  task automatic test_waw();
    alloc_valid = 1; alloc_rd = 5'd9;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL waw_first got %0b exp 1", alloc_ready); end
    tick();
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL waw_second got %0b exp 0", alloc_ready); end
    alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h99;
    tick();
    alu_valid = 0;
    #1;
    checks++; if ({rf_wen, alloc_ready} !== 2'b10) begin errors++; $display("FAIL waw_during_commit got wen %0b rdy %0b exp 1 0", rf_wen, alloc_ready); end
    tick();
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL waw_after_commit got %0b exp 1", alloc_ready); end
    tick();
    alloc_valid = 0;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h98;
    tick();
    alu_valid = 0;
    tick();
  endtask

  task automatic test_reset_midstream();
    for (int r = 10; r < 13; r++) begin
      alloc_valid = 1; alloc_rd = AW'(r);
      tick();
    end
    alloc_valid = 0;
    for (int r = 10; r < 13; r++) begin
      lsu_valid = 1; lsu_rd = AW'(r); lsu_data = 64'h100 + 64'(r);
      tick();
    end
    lsu_valid = 0;
    chk_raddr1 = 5'd12; chk_raddr2 = 5'd11; alloc_rd = 5'd11;
    #1;
    checks++; if ({rf_wen, rf_waddr, hazard1} !== {1'b1, 5'd12, 1'b1}) begin errors++; $display("FAIL midrst_pre got %0b %0d %0b exp 1 12 1", rf_wen, rf_waddr, hazard1); end
    #1 rst_n = 0;
    #1;
    checks++; if ({rf_wen, pending} !== {1'b0, 3'd0}) begin errors++; $display("FAIL midrst_flush got wen %0b pend %0d exp 0 0", rf_wen, pending); end
    checks++; if ({hazard1, hazard2, alloc_ready} !== 3'b001) begin errors++; $display("FAIL midrst_busy got %b exp 001", {hazard1, hazard2, alloc_ready}); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL midrst_no_replay cyc %0d got %0b exp 0", i, rf_wen); end
    end
  endtask

  task automatic test_random();
    wb_entry_t h;
    int idx;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(lsu_valid && !acc_lsu)) begin
        lsu_valid = 0;
        if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
          idx = $urandom_range(0, outst.size() - 1);
          lsu_valid = 1; lsu_rd = AW'(outst[idx]); outst.delete(idx);
          lsu_data = {$urandom, $urandom};
        end else if ($urandom_range(0, 9) == 0) begin
          lsu_valid = 1; lsu_rd = 0; lsu_data = {$urandom, $urandom};
        end
      end
      if (!(alu_valid && !acc_alu)) begin
        alu_valid = 0;
        if (outst.size() > 0 && $urandom_range(0, 1) == 0) begin
          idx = $urandom_range(0, outst.size() - 1);
          alu_valid = 1; alu_rd = AW'(outst[idx]); outst.delete(idx);
          alu_data = {$urandom, $urandom};
        end else if ($urandom_range(0, 9) == 0) begin
          alu_valid = 1; alu_rd = 0; alu_data = {$urandom, $urandom};
        end
      end
      if (!(alloc_valid && !acc_alloc)) begin
        alloc_valid = ($urandom_range(0, 1) == 1);
        alloc_rd = AW'($urandom_range(0, 31));
      end
      chk_raddr1 = AW'($urandom_range(0, 31));
      chk_raddr2 = AW'($urandom_range(0, 31));
      #1;
      if (q.size() > 0) h = q[0];
      else h = '0;
      checks++; if (rf_wen !== (q.size() > 0)) begin errors++; $display("FAIL rand_wen cyc %0d got %0b exp %0b", cyc, rf_wen, q.size() > 0); end
      checks++; if ({rf_waddr, rf_wdata} !== {h.rd, h.data}) begin errors++; $display("FAIL rand_write cyc %0d got %0d/%0h exp %0d/%0h", cyc, rf_waddr, rf_wdata, h.rd, h.data); end
      checks++; if (pending !== 3'(q.size())) begin errors++; $display("FAIL rand_pending cyc %0d got %0d exp %0d", cyc, pending, q.size()); end
      checks++; if ({lsu_ready, alu_ready} !== {q.size() != DEPTH, q.size() != DEPTH && !lsu_valid}) begin errors++; $display("FAIL rand_ready cyc %0d got %b", cyc, {lsu_ready, alu_ready}); end
      checks++; if (alloc_ready !== !mbusy[alloc_rd]) begin errors++; $display("FAIL rand_alloc_ready cyc %0d rd %0d got %0b exp %0b", cyc, alloc_rd, alloc_ready, !mbusy[alloc_rd]); end
      checks++; if ({hazard1, hazard2} !== {mbusy[chk_raddr1], mbusy[chk_raddr2]}) begin errors++; $display("FAIL rand_hazard cyc %0d got %b exp %b", cyc, {hazard1, hazard2}, {mbusy[chk_raddr1], mbusy[chk_raddr2]}); end
      tick();
      if (acc_alloc && alloc_rd != 0) outst.push_back(int'(alloc_rd));
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_hazard();
    test_arbitration();
    test_x0();
    test_waw();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
